fixed_point_exp_input_stream: RTL
=================================

# fixed_point_exp_input_stream

Parametrised successor to the four-lane exp-input stage: computes max(x) − x_i for CHANNELS fixed-point softmax inputs and streams the differences to the exponential unit LANES results per beat under a valid/ready handshake. Sits between the max-finder and the exp pipeline; unlike the fixed four-lane stage it supports arbitrary channel counts, back-pressure, partial final beats and optional saturation.

## Interface
- DATA_WIDTH, 32, total bits per two's-complement fixed-point word
- INTEGER, 16, integer bits (incl. sign)
- FRACTION, 16, fraction bits; INTEGER+FRACTION == DATA_WIDTH
- CHANNELS, 10, number of softmax inputs (≥1)
- LANES, 4, results per output beat (1 ≤ LANES ≤ CHANNELS)
- BEATS (localparam), ceil(CHANNELS/LANES)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- softmax_enable  in  1  start request; sampled only in IDLE
- in_vec  in  CHANNELS*DATA_WIDTH  packed inputs, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- max_input  in  DATA_WIDTH  max of all channels
- out_data  out  LANES*DATA_WIDTH  differences, lane j = channel beat*LANES+j
- out_lane_mask  out  LANES  bit j set when lane j holds a real channel
- out_valid  out  1  out_data/out_lane_mask/out_last valid
- out_ready  in  1  consumer accepts beat when out_valid && out_ready
- out_last  out  1  current beat is beat BEATS−1
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after last beat accepted

## Operation
- States: IDLE, FILL, SEND.
- IDLE: busy=0, out_valid=0. softmax_enable=1 → capture in_vec and max_input into internal registers, beat counter=0, go FILL.
- FILL (1 cycle): register beat 0 results into out_data/out_lane_mask/out_last, set out_valid, go SEND.
- SEND: while out_valid && !out_ready, all outputs hold exactly. On handshake: if beat==BEATS−1 → out_valid=0, done=1 for one cycle, go IDLE; else beat+1, load next beat's results, out_valid stays 1 (back-to-back beats).
- Arithmetic: diff = max_input − x_i on captured values, two's complement, same Q(INTEGER.FRACTION) format, no rescaling; default result truncated to DATA_WIDTH (wrap).
- Partial last beat: lanes with channel index ≥ CHANNELS output 0, mask bit 0. out_lane_mask all-ones on full beats.
- softmax_enable in FILL/SEND ignored; captured values unaffected by later input changes.
- Reset (any state, including mid-SEND): state=IDLE, beat=0, out_data=0, out_lane_mask=0, out_valid=0, out_last=0, busy=0, done=0, captured registers=0. Pending beats discarded.

## Timing
- softmax_enable high at edge k → busy=1 after k; out_valid=1 with beat 0 after edge k+1.
- With out_ready held 1: beat b valid after edge k+1+b; done=1 after edge k+1+BEATS, busy=0 same cycle.
- Earliest restart: softmax_enable sampled at the edge where done is asserted (IDLE).
- out_valid never drops without a handshake, except reset.
- BEATS==1: out_last=1 on the only beat.

## Configuration
- EXP_IN_SAT_EN defined: difference computed at DATA_WIDTH+1 bits; overflow clamps to most positive (0x7FFF_FFFF for 32 bits) or most negative (0x8000_0000) value.
- Undefined: plain DATA_WIDTH wrap-around subtraction; no extra logic.

## Test plan
- Defaults, max=0x0005_0000, ch0=0x0002_0000, ch1=0x0005_0000, others 0x0001_0000, out_ready=1 → beat0 lanes {0x0003_0000,0,0x0004_0000,0x0004_0000}; 3 beats; beat2 mask 4'b0011, lanes 2–3 = 0, out_last=1; done one cycle after beat2.
- out_ready low 3 cycles during beat 1 → out_data, mask, out_last stable; beat 2 follows one cycle after release; no beat lost or duplicated.
- max=0x7FFF_0000, ch0=0x8000_0000 → lane0 0xFFFF_0000 without EXP_IN_SAT_EN; 0x7FFF_FFFF with it.
- softmax_enable pulsed again in SEND with changed in_vec → ignored; outputs reflect first capture.
- reset asserted during beat 1 → next edge all outputs 0, IDLE; fresh enable yields full 3-beat sequence from beat 0.
- CHANNELS=4, LANES=4 → single beat, mask 4'b1111, out_last=1, done after one handshake.

Source files
------------

// File: rtl/fixed_point_exp_input_stream.sv
// fixed_point_exp_input_stream: streams max_input - x_i for CHANNELS fixed-point inputs, LANES per valid/ready beat; define EXP_IN_SAT_EN to saturate instead of wrap
module fixed_point_exp_input_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int INTEGER    = 16,
    parameter int FRACTION   = 16,
    parameter int CHANNELS   = 10,
    parameter int LANES      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         softmax_enable,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_vec,
    input  logic [DATA_WIDTH-1:0]        max_input,
    output logic [LANES*DATA_WIDTH-1:0]  out_data,
    output logic [LANES-1:0]             out_lane_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);
    localparam int DW    = DATA_WIDTH;
    localparam int BEATS = (CHANNELS + LANES - 1) / LANES;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    if (INTEGER + FRACTION != DATA_WIDTH) begin : g_bad_format
        $error("INTEGER + FRACTION must equal DATA_WIDTH");
    end
    typedef enum logic [1:0] {IDLE, FILL, SEND} state_t;
    state_t                  state, state_n;
    logic [BW-1:0]           beat, beat_n;
    logic [CHANNELS*DW-1:0]  cap_vec;
    logic [DW-1:0]           cap_max;
    logic [BEATS*LANES*DW-1:0] pad_data;
    logic [BEATS*LANES-1:0]  pad_mask;
    logic                    capture, load, valid_n, done_n, fire, last_beat;
    genvar i;
    for (i = 0; i < BEATS * LANES; i++) begin : g_lane
        if (i < CHANNELS) begin : g_real
            logic [DW-1:0] x;
            assign x = cap_vec[i*DW +: DW];
`ifdef EXP_IN_SAT_EN
            logic [DW:0] w;
            assign w = {cap_max[DW-1], cap_max} - {x[DW-1], x};
            assign pad_data[i*DW +: DW] = (w[DW] != w[DW-1]) ? {w[DW], {(DW-1){~w[DW]}}} : w[DW-1:0];
`else
            assign pad_data[i*DW +: DW] = cap_max - x;
`endif
            assign pad_mask[i] = 1'b1;
        end else begin : g_pad
            assign pad_data[i*DW +: DW] = '0;
            assign pad_mask[i] = 1'b0;
        end
    end
    assign fire      = out_valid && out_ready;
    assign last_beat = beat == BW'(BEATS - 1);
    assign busy      = state != IDLE;
    always_comb begin
        state_n = state;
        beat_n  = beat;
        capture = 1'b0;
        load    = 1'b0;
        valid_n = out_valid;
        done_n  = 1'b0;
        case (state)
            IDLE: if (softmax_enable) begin
                capture = 1'b1;
                beat_n  = '0;
                state_n = FILL;
            end
            FILL: begin
                load    = 1'b1;
                valid_n = 1'b1;
                state_n = SEND;
            end
            SEND: if (fire) begin
                if (last_beat) begin
                    valid_n = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    beat_n = beat + 1'b1;
                    load   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            beat          <= '0;
            cap_vec       <= '0;
            cap_max       <= '0;
            out_data      <= '0;
            out_lane_mask <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            done          <= 1'b0;
        end else begin
            state     <= state_n;
            beat      <= beat_n;
            out_valid <= valid_n;
            done      <= done_n;
            if (capture) begin
                cap_vec <= in_vec;
                cap_max <= max_input;
            end
            if (load) begin
                out_data      <= pad_data[beat_n*LANES*DW +: LANES*DW];
                out_lane_mask <= pad_mask[beat_n*LANES +: LANES];
                out_last      <= beat_n == BW'(BEATS - 1);
            end
        end
    end
endmodule
